// File: rtl/fsk_demodulator.sv
// FSK demodulator: one-sample quadrature discriminator, integrate-and-dump per
// symbol, and a symbol timing counter that locks to discriminator sign changes.
`ifndef SinSize
`define SinSize 8
`endif

module fsk_demodulator #(
  parameter int SIN_SIZE    = `SinSize,
  parameter int SPS         = 4,
  parameter int ACQ_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  input  logic [SIN_SIZE-1:0] FSK_I,
  input  logic [SIN_SIZE-1:0] FSK_Q,
  output logic                symVal,
  output logic                symValid,
  output logic                locked
);

  localparam int DW = 2 * SIN_SIZE + 1;
  localparam int AW = DW + $clog2(SPS) + 1;
  localparam int PW = $clog2(SPS);
  localparam int CW = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);
  localparam logic [PW-1:0] PH_PRE  = PW'(SPS - 2);
  localparam logic [PW-1:0] PH_HALF = PW'(SPS / 2);

  typedef enum logic {ACQ, TRACK} state_t;

  logic signed [SIN_SIZE-1:0] r_iCur, r_qCur, r_iPrev, r_qPrev;
  logic                       r_histOk, r_pairOk;
  logic signed [DW-1:0]       r_disc;
  logic                       r_discValid;
  state_t                     r_state, w_nextState;
  logic [CW-1:0]              r_acqCnt;
  logic [PW-1:0]              r_phase, w_nextPhase;
  logic signed [AW-1:0]       r_acc, w_nextAcc, w_accSum;
  logic                       r_adjDone, w_nextAdj;
  logic [1:0]                 r_lastSgn, w_sgn;
  logic                       r_dumpPend, r_dumpPos, r_dumpNeg;
  logic                       r_symVal, r_symValid;

  logic signed [DW-1:0] w_iPrevX, w_qPrevX, w_iCurX, w_qCurX, w_prodA, w_prodB;
  logic w_advance, w_discZero, w_trans, w_acqDone;
  logic w_stretch, w_late, w_dump, w_trackDump;

  // Stage 1: sample history; every pipeline stage advances only on inValid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iCur   <= '0;
      r_qCur   <= '0;
      r_iPrev  <= '0;
      r_qPrev  <= '0;
      r_histOk <= 1'b0;
      r_pairOk <= 1'b0;
    end else if (inValid) begin
      r_iCur   <= $signed(FSK_I);
      r_qCur   <= $signed(FSK_Q);
      r_iPrev  <= r_iCur;
      r_qPrev  <= r_qCur;
      r_histOk <= 1'b1;
      r_pairOk <= r_histOk;
    end
  end

  assign w_iPrevX = DW'(r_iPrev);
  assign w_qPrevX = DW'(r_qPrev);
  assign w_iCurX  = DW'(r_iCur);
  assign w_qCurX  = DW'(r_qCur);
  assign w_prodA  = w_iPrevX * w_qCurX;
  assign w_prodB  = w_qPrevX * w_iCurX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disc      <= '0;
      r_discValid <= 1'b0;
    end else if (inValid) begin
      r_disc      <= w_prodA - w_prodB;
      r_discValid <= r_pairOk;
    end
  end

  // Sign encoding: 00 zero, 01 positive, 10 negative; a zero disc never counts
  assign w_advance  = inValid & r_discValid;
  assign w_discZero = (r_disc == '0);
  assign w_sgn      = w_discZero ? 2'b00 : (r_disc[DW-1] ? 2'b10 : 2'b01);
  assign w_trans    = !w_discZero && (r_lastSgn != 2'b00) && (w_sgn != r_lastSgn);
  assign w_acqDone  = (r_acqCnt == CW'(ACQ_TIMEOUT - 1));
  assign w_accSum   = r_acc + AW'(r_disc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ACQ;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == ACQ && w_advance && (w_trans || w_acqDone)) w_nextState = TRACK;
  end

  // Timing recovery: an early boundary holds the phase once, a late one skips
  // ahead; a late transition on the dump sample shortens the following symbol.
  always_comb begin
    w_stretch   = 1'b0;
    w_late      = 1'b0;
    w_dump      = 1'b0;
    w_nextPhase = r_phase;
    w_nextAcc   = r_acc;
    w_nextAdj   = r_adjDone;
    if (r_state == ACQ) begin
      w_nextAdj = 1'b0;
      if (w_trans) begin
        w_nextPhase = PW'(1);
        w_nextAcc   = AW'(r_disc);
      end else begin
        w_nextPhase = '0;
        w_nextAcc   = '0;
      end
    end else begin
      w_stretch = w_trans && !r_adjDone && (r_phase != '0) && (r_phase <= PH_HALF);
      w_late    = w_trans && !r_adjDone && (r_phase > PH_HALF);
      w_dump    = (r_phase == PH_LAST) || (w_late && (r_phase == PH_PRE));
      if (w_stretch)                         w_nextPhase = r_phase;
      else if (w_late && r_phase == PH_LAST) w_nextPhase = PW'(1);
      else if (w_dump)                       w_nextPhase = '0;
      else if (w_late)                       w_nextPhase = r_phase + PW'(2);
      else                                   w_nextPhase = r_phase + PW'(1);
      if (w_dump) begin
        w_nextAcc = '0;
        w_nextAdj = w_late && (r_phase == PH_LAST);
      end else begin
        w_nextAcc = w_accSum;
        w_nextAdj = r_adjDone | w_stretch | w_late;
      end
    end
  end

  assign w_trackDump = w_advance && (r_state == TRACK) && w_dump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acqCnt  <= '0;
      r_phase   <= '0;
      r_acc     <= '0;
      r_adjDone <= 1'b0;
      r_lastSgn <= 2'b00;
      r_dumpPos <= 1'b0;
      r_dumpNeg <= 1'b0;
    end else if (w_advance) begin
      r_phase   <= w_nextPhase;
      r_acc     <= w_nextAcc;
      r_adjDone <= w_nextAdj;
      if (!w_discZero)      r_lastSgn <= w_sgn;
      if (r_state == ACQ)   r_acqCnt  <= r_acqCnt + CW'(1);
      if (w_trackDump) begin
        r_dumpPos <= (w_accSum != '0) && !w_accSum[AW-1];
        r_dumpNeg <= w_accSum[AW-1];
      end
    end
  end

  // Output stage: the strobe leaves with the next valid sample, a zero sum holds symVal
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dumpPend <= 1'b0;
      r_symValid <= 1'b0;
      r_symVal   <= 1'b0;
    end else begin
      r_symValid <= inValid && r_dumpPend;
      if (inValid) begin
        r_dumpPend <= w_trackDump;
        if (r_dumpPend && r_dumpPos)      r_symVal <= 1'b1;
        else if (r_dumpPend && r_dumpNeg) r_symVal <= 1'b0;
      end
    end
  end

  always_comb begin
    locked = (r_state == TRACK);
  end

  assign symVal   = r_symVal;
  assign symValid = r_symValid;

endmodule
